// File: rtl/ts_stream_switch.sv
// Transport-stream channel switch: forwards one of NUM_CH byte streams and
// changes channel only on packet boundaries (manual select or auto failover).
module ts_stream_switch #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 8,
  parameter int PKT_LEN = 188,
  parameter int SEL_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        valid_in,
  input  logic [NUM_CH-1:0]        sync_in,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  input  logic [SEL_W-1:0]         sel_req,
  input  logic                     sel_req_vld,
  input  logic                     auto_en,
  input  logic [NUM_CH-1:0]        ch_ok,
  output logic                     valid_out,
  output logic                     sync_out,
  output logic [DATA_W-1:0]        data_out,
  output logic [SEL_W-1:0]         active_ch,
  output logic                     switch_done,
  output logic                     sel_err
);

  localparam int CNT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PKT_LEN - 1);

  typedef enum logic [1:0] {ALIGN, PASS, DRAIN} state_t;

  state_t             state_q;
  logic               valid_q, sync_q, done_q, err_q, chg_q;
  logic [DATA_W-1:0]  data_q;
  logic [SEL_W-1:0]   active_q, pend_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               a_vld, a_sync, a_ok;
  logic [DATA_W-1:0]  a_data;
  logic               req_in_rng, req_new, req_bad;
  logic               fo_found, fo_go;
  logic [SEL_W-1:0]   fo_ch, pend_d;
  logic [CNT_W-1:0]   cnt_d;

  // Active-channel lane mux
  always_comb begin
    a_vld  = 1'b0;
    a_sync = 1'b0;
    a_ok   = 1'b0;
    a_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (active_q == SEL_W'(i)) begin
        a_vld  = valid_in[i];
        a_sync = sync_in[i];
        a_ok   = ch_ok[i];
        a_data = data_in[i*DATA_W +: DATA_W];
      end
    end
  end

  // Failover target: first healthy channel above active_ch, wrapping
  always_comb begin
    fo_found = 1'b0;
    fo_ch    = '0;
    for (int k = 1; k < NUM_CH; k++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!fo_found && ch_ok[i] && ((int'(active_q) + k) % NUM_CH) == i) begin
          fo_found = 1'b1;
          fo_ch    = SEL_W'(i);
        end
      end
    end
  end

  always_comb begin
    req_in_rng = sel_req_vld && (int'(sel_req) < NUM_CH);
    req_bad    = sel_req_vld && !req_in_rng;
    req_new    = req_in_rng && (sel_req != active_q);
    fo_go      = auto_en && !a_ok && fo_found;
    pend_d     = req_new ? sel_req : pend_q;
    cnt_d      = (a_sync || cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ALIGN;
      valid_q  <= 1'b0;
      sync_q   <= 1'b0;
      data_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      chg_q    <= 1'b0;
      active_q <= '0;
      pend_q   <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      sync_q  <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= req_bad;
      case (state_q)
        ALIGN: begin
          // Nothing is in flight, so a new target takes effect at once
          if (req_new) begin
            active_q <= sel_req;
            pend_q   <= sel_req;
            chg_q    <= 1'b1;
          end else if (fo_go) begin
            active_q <= fo_ch;
            pend_q   <= fo_ch;
            chg_q    <= 1'b1;
          end else if (a_vld && a_sync) begin
            valid_q <= 1'b1;
            sync_q  <= 1'b1;
            data_q  <= a_data;
            cnt_q   <= '0;
            done_q  <= chg_q;
            chg_q   <= 1'b0;
            state_q <= PASS;
          end
        end
        PASS: begin
          if (a_vld) begin
            valid_q <= 1'b1;
            sync_q  <= a_sync;
            data_q  <= a_data;
            cnt_q   <= cnt_d;
          end
          if (req_new) begin
            pend_q  <= sel_req;
            state_q <= DRAIN;
          end else if (fo_go) begin
            pend_q  <= fo_ch;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          pend_q <= pend_d;
          // A sync on the old channel closes the packet early and is dropped
          if (a_vld && a_sync) begin
            active_q <= pend_d;
            chg_q    <= 1'b1;
            cnt_q    <= '0;
            state_q  <= ALIGN;
          end else if (a_vld) begin
            valid_q <= 1'b1;
            data_q  <= a_data;
            cnt_q   <= cnt_d;
            if (cnt_d == LAST) begin
              active_q <= pend_d;
              chg_q    <= 1'b1;
              cnt_q    <= '0;
              state_q  <= ALIGN;
            end
          end
        end
        default: state_q <= ALIGN;
      endcase
    end
  end

  assign valid_out   = valid_q;
  assign sync_out    = sync_q;
  assign data_out    = data_q;
  assign active_ch   = active_q;
  assign switch_done = done_q;
  assign sel_err     = err_q;

endmodule

// File: tb/tb_ts_stream_switch.sv
// Directed bench: four free-running 188-byte sources with distinct phases,
// driven through a table of windows with hand-computed output statistics.
module tb_ts_stream_switch;

  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int PL  = 188;
  localparam int SW  = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    valid_in, sync_in, ch_ok;
  logic [NCH*DW-1:0] data_in;
  logic [SW-1:0]     sel_req;
  logic              sel_req_vld, auto_en;
  logic              valid_out, sync_out, switch_done, sel_err;
  logic [DW-1:0]     data_out;
  logic [SW-1:0]     active_ch;

  ts_stream_switch #(.NUM_CH(NCH), .DATA_W(DW), .PKT_LEN(PL), .SEL_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .sync_in(sync_in),
    .data_in(data_in), .sel_req(sel_req), .sel_req_vld(sel_req_vld),
    .auto_en(auto_en), .ch_ok(ch_ok), .valid_out(valid_out), .sync_out(sync_out),
    .data_out(data_out), .active_ch(active_ch), .switch_done(switch_done),
    .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    bit         sv;
    logic [2:0] sel;
    bit         au;
    logic [3:0] ok;
    int         e_vld, e_sync, e_done, e_err, e_act, e_ch;
  } vec_t;

  vec_t tbl[15];
  int   off[NCH] = '{0, 20, 60, 100};
  int   t, n_chk, n_fail;
  int   c_vld, c_sync, c_done, c_err, c_badch, exp_ch;

  task automatic check(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic clr();
    c_vld = 0; c_sync = 0; c_done = 0; c_err = 0; c_badch = 0;
  endtask

  // Drive every channel for global time t, clock once, observe the result
  task automatic step();
    for (int c = 0; c < NCH; c++) begin
      int idx;
      logic [7:0] b;
      logic [1:0] cc;
      idx = (t + off[c]) % PL;
      cc  = 2'(c);
      b   = (idx == 0) ? 8'h47 : {cc, 6'(idx % 64)};
      valid_in[c]       = 1'b1;
      sync_in[c]        = (idx == 0);
      data_in[c*DW +: DW] = b;
    end
    @(posedge clk);
    #1;
    if (valid_out) begin
      c_vld++;
      if (sync_out) c_sync++;
      else if (int'(data_out[7:6]) != exp_ch) c_badch++;
    end
    if (switch_done) c_done++;
    if (sel_err) c_err++;
    sel_req_vld = 1'b0;
    t++;
  endtask

  initial begin
    // n, pulse, sel, auto, ok, vld, sync, done, err, active, channel
    tbl[0]  = '{187, 0, 0, 0, 4'hF, 187, 0, 0, 0, 0, 0};
    tbl[1]  = '{50,  0, 0, 0, 4'hF, 50,  1, 0, 0, 0, 0};
    tbl[2]  = '{266, 1, 2, 0, 4'hF, 138, 0, 0, 0, 2, 0};
    tbl[3]  = '{17,  0, 0, 0, 4'hF, 17,  1, 1, 0, 2, 2};
    tbl[4]  = '{10,  1, 5, 0, 4'hF, 10,  0, 0, 1, 2, 2};
    tbl[5]  = '{309, 0, 0, 1, 4'hB, 161, 0, 0, 0, 3, 2};
    tbl[6]  = '{20,  0, 0, 0, 4'hF, 20,  1, 1, 0, 3, 3};
    tbl[7]  = '{10,  1, 1, 0, 4'hF, 10,  0, 0, 0, 3, 3};
    tbl[8]  = '{198, 1, 2, 0, 4'hF, 158, 0, 0, 0, 2, 3};
    tbl[9]  = '{32,  0, 0, 0, 4'hF, 32,  1, 1, 0, 2, 2};
    tbl[10] = '{156, 1, 0, 0, 4'hF, 156, 0, 0, 0, 0, 2};
    tbl[11] = '{40,  1, 1, 0, 4'hF, 0,   0, 0, 0, 1, 1};
    tbl[12] = '{15,  0, 0, 0, 4'hF, 15,  1, 1, 0, 1, 1};
    tbl[13] = '{5,   1, 1, 0, 4'hF, 5,   0, 0, 0, 1, 1};
    tbl[14] = '{184, 0, 0, 1, 4'h0, 184, 1, 0, 0, 1, 1};

    n_chk = 0; n_fail = 0; t = 0; exp_ch = 0;
    rst_n = 1'b0; valid_in = '0; sync_in = '0; data_in = '0;
    sel_req = 3'd5; sel_req_vld = 1'b1; auto_en = 1'b0; ch_ok = 4'hF;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", int'(valid_out), 0);
    check("rst_sync", int'(sync_out), 0);
    check("rst_data", int'(data_out), 0);
    check("rst_active", int'(active_ch), 0);
    check("rst_done", int'(switch_done), 0);
    check("rst_err", int'(sel_err), 0);
    sel_req_vld = 1'b0;
    rst_n = 1'b1;

    // First ch0 byte is a sync and comes out one cycle later
    clr();
    step();
    check("first_valid", int'(valid_out), 1);
    check("first_sync", int'(sync_out), 1);
    check("first_data", int'(data_out), 'h47);
    check("first_done", int'(switch_done), 0);

    for (int i = 0; i < 15; i++) begin
      clr();
      exp_ch  = tbl[i].e_ch;
      auto_en = tbl[i].au;
      ch_ok   = tbl[i].ok;
      sel_req = tbl[i].sel;
      sel_req_vld = tbl[i].sv;
      for (int k = 0; k < tbl[i].n; k++) step();
      check($sformatf("w%0d_valid", i), c_vld, tbl[i].e_vld);
      check($sformatf("w%0d_sync", i), c_sync, tbl[i].e_sync);
      check($sformatf("w%0d_done", i), c_done, tbl[i].e_done);
      check($sformatf("w%0d_err", i), c_err, tbl[i].e_err);
      check($sformatf("w%0d_active", i), int'(active_ch), tbl[i].e_act);
      check($sformatf("w%0d_chan", i), c_badch, 0);
    end

    // Reset in the middle of a ch1 packet, then wait for the next ch0 sync
    auto_en = 1'b0; ch_ok = 4'hF; exp_ch = 1;
    while (t < 1584) step();
    check("pre_rst_valid", int'(valid_out), 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", int'(valid_out), 0);
    check("rst_mid_active", int'(active_ch), 0);
    clr();
    repeat (6) step();
    check("rst_hold_valid", c_vld, 0);
    rst_n = 1'b1;
    exp_ch = 0;
    clr();
    while (t < 1692) step();
    check("post_rst_idle", c_vld, 0);
    clr();
    step();
    check("resume_valid", int'(valid_out), 1);
    check("resume_sync", int'(sync_out), 1);
    check("resume_data", int'(data_out), 'h47);
    check("resume_done", int'(switch_done), 0);
    repeat (20) step();
    check("resume_count", c_vld, 21);
    check("resume_chan", c_badch, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ts_stream_switch.md
TS_STREAM_SWITCH -- requirements
Module: ts_stream_switch

Interface
REQ-001 Parameter NUM_CH, default 4, number of input transport-stream channels (2..16).
REQ-002 Parameter DATA_W, default 8, byte-lane width.
REQ-003 Parameter PKT_LEN, default 188, TS packet length in bytes.
REQ-004 Parameter SEL_W, default 2, select width; SHALL satisfy 2**SEL_W >= NUM_CH.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clk  in  1  single clock; all logic samples on its rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 valid_in  in  NUM_CH  per-channel byte strobe, bit i = channel i.
REQ-009 sync_in  in  NUM_CH  per-channel packet-start flag, meaningful only with valid_in.
REQ-010 data_in  in  NUM_CH*DATA_W  packed bytes, channel i at bits [i*DATA_W +: DATA_W].
REQ-011 sel_req  in  SEL_W  requested channel index.
REQ-012 sel_req_vld  in  1  one-cycle strobe qualifying sel_req.
REQ-013 auto_en  in  1  enables automatic failover.
REQ-014 ch_ok  in  NUM_CH  per-channel health (1 = usable).
REQ-015 valid_out  out  1  output byte strobe.
REQ-016 sync_out  out  1  output packet-start flag.
REQ-017 data_out  out  DATA_W  output byte.
REQ-018 active_ch  out  SEL_W  channel currently forwarded.
REQ-019 switch_done  out  1  one-cycle pulse when the first sync byte of a new channel is forwarded.
REQ-020 sel_err  out  1  one-cycle pulse on rejected request.

Function
REQ-021 Outputs valid_out, sync_out, data_out SHALL be registered: input in cycle N appears in cycle N+1.
REQ-022 States: ALIGN (waiting for sync on active_ch, outputs suppressed), PASS (forwarding active_ch), DRAIN (switch pending, finishing current packet).
REQ-023 ALIGN -> PASS on valid_in[active_ch] & sync_in[active_ch]; that byte SHALL be forwarded with sync_out=1.
REQ-024 In PASS/DRAIN a byte counter SHALL count 0..PKT_LEN-1 on each valid_in[active_ch], reset to 0 on the sync byte.
REQ-025 Sync byte on active channel with counter != PKT_LEN-1 SHALL restart the counter at 0 (short packet accepted, no error).
REQ-026 In PASS, sel_req_vld with sel_req < NUM_CH and sel_req != active_ch SHALL latch pending_ch and enter DRAIN.
REQ-027 sel_req >= NUM_CH SHALL be ignored and raise sel_err next cycle; sel_req == active_ch SHALL be ignored silently.
REQ-028 A new valid request during DRAIN or ALIGN SHALL overwrite pending_ch (last request wins); in ALIGN it SHALL retarget active_ch immediately.
REQ-029 DRAIN SHALL forward bytes until the byte with counter = PKT_LEN-1 is forwarded, then set active_ch = pending_ch and enter ALIGN next cycle.
REQ-030 Sync byte on old channel while in DRAIN SHALL end the packet: not forwarded, switch performed as in REQ-029.
REQ-031 Auto failover: with auto_en=1 and ch_ok[active_ch]=0 in PASS, pending_ch SHALL be the first i with ch_ok[i]=1 searching active_ch+1 upward with wrap; enter DRAIN.
REQ-032 Auto failover in ALIGN SHALL retarget active_ch immediately by the same search.
REQ-033 If no channel is ok, active_ch SHALL remain unchanged and no switch occurs.
REQ-034 Manual request and failover in same cycle: manual request wins.
REQ-035 Bytes from non-active channels SHALL never reach the output; no partial packet SHALL be emitted after a switch.
REQ-036 switch_done SHALL pulse only on the first ALIGN->PASS following a channel change.

Reset
REQ-037 While rst_n=0: valid_out=0, sync_out=0, data_out=0, active_ch=0, switch_done=0, sel_err=0, counter=0, pending cleared, state=ALIGN.
REQ-038 Reset asserted mid-packet SHALL abort immediately; after release the block SHALL wait for sync on channel 0.

Verification
REQ-039 Channel 0 sends 188-byte packets from reset, first byte 0x47 -> first output 0x47 with sync_out=1 one cycle later, 188 valid_out bytes per packet.
REQ-040 sel_req=2 pulsed at byte 50 of ch0 packet -> remaining 138 bytes of ch0 forwarded, then nothing until ch2 sync; switch_done pulses with that sync byte, active_ch=2.
REQ-041 sel_req=5 with NUM_CH=4 -> sel_err pulse, active_ch and output unchanged.
REQ-042 auto_en=1, ch_ok=4'b1011, active_ch=2, ch_ok[2] drops mid-packet -> packet completes, active_ch becomes 3.
REQ-043 Requests 1 then 3 during one DRAIN -> switch goes to ch3 only, no ch1 byte output.
REQ-044 rst_n pulsed low at byte 100 of a packet -> valid_out=0 immediately, resumes only at next ch0 sync byte.
